// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: shares one write port between the in-order
// writeback stage and a buffered long-latency unit, and tracks pending LLU writes.
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_stall_o,
  input  logic        llu_valid_i,
  output logic        llu_ready_o,
  input  logic [4:0]  llu_rd_i,
  input  logic [31:0] llu_data_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  rs1_q_i,
  input  logic [4:0]  rs2_q_i,
  input  logic [4:0]  rd_q_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        rd_busy_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_data_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LIMIT_CNT = 4'(STARVE_LIMIT);

  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    starve_q, starve_d;
  logic [31:0]   pending_q, pending_d;

  logic          wb_req;
  logic          fifo_empty;
  logic          force_pop;
  logic          llu_fire;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at the registered count, so a same-cycle pop never raises it.
  assign llu_ready_o = !rst_i && (count_q < DEPTH_CNT);
  assign llu_fire    = llu_valid_i && llu_ready_o;
  assign push        = llu_fire && (llu_rd_i != 5'd0);

  assign wb_req      = wb_en_i && (wb_rd_i != 5'd0);
  assign fifo_empty  = (count_q == '0);
  assign force_pop   = (starve_q == LIMIT_CNT);
  assign head_rd     = fifo_rd_q[rd_ptr_q];
  assign head_data   = fifo_data_q[rd_ptr_q];
  assign pop         = !rst_i && !fifo_empty && (force_pop || !wb_req);

  always_comb begin
    rf_we_o    = 1'b0;
    rf_rd_o    = 5'd0;
    rf_data_o  = 32'd0;
    wb_stall_o = 1'b0;
    if (pop) begin
      rf_we_o    = 1'b1;
      rf_rd_o    = head_rd;
      rf_data_o  = head_data;
      wb_stall_o = force_pop && wb_req;
    end else if (wb_req && !rst_i) begin
      rf_we_o    = 1'b1;
      rf_rd_o    = wb_rd_i;
      rf_data_o  = wb_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Counts denied cycles of a waiting head; it can never pass the limit because
  // reaching it forces a pop, which clears it.
  always_comb begin
    if (fifo_empty || pop) begin
      starve_d = 4'd0;
    end else begin
      starve_d = starve_q + 4'd1;
    end
  end

  // A new issue to the same register outranks the commit of the older one.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_rd] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != 5'd0)) begin
      pending_d[issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  assign rs1_busy_o = pending_q[rs1_q_i];
  assign rs2_busy_o = pending_q[rs2_q_i];
  assign rd_busy_o  = pending_q[rd_q_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= 4'd0;
      pending_q <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  // Entry storage needs no reset; the count alone says which slots are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= llu_rd_i;
      fifo_data_q[wr_ptr_q] <= llu_data_i;
    end
  end

endmodule
